// File: rtl/multi_mode_counter.sv
// rtl/multi_mode_counter.sv - multi-channel up/down counter with shared terminal value
// Each channel runs an IDLE/RUN/HOLD FSM; per-edge priority is load > stop > start > count.
module multi_mode_counter #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter bit ONESHOT  = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       dir,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0]          limit,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state   [CHANNELS];
  logic [WIDTH-1:0] cur     [CHANNELS];
  logic [WIDTH-1:0] term    [CHANNELS];
  logic [WIDTH-1:0] rst_val [CHANNELS];

  // Up-counters stop at limit and restart at 0; down-counters mirror that.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cur[i]     = count[i*WIDTH +: WIDTH];
      term[i]    = dir[i] ? '0 : limit;
      rst_val[i] = dir[i] ? limit : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) state[i] <= IDLE;
      count <= '0;
      busy  <= '0;
      done  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        done[i] <= 1'b0;
        if (load[i]) begin
          count[i*WIDTH +: WIDTH] <= load_val[i*WIDTH +: WIDTH];
        end else if (stop[i]) begin
          if (state[i] == RUN) begin
            state[i] <= IDLE;
            busy[i]  <= 1'b0;
          end
        end else if (start[i]) begin
          if (state[i] != RUN) begin
            state[i] <= RUN;
            busy[i]  <= 1'b1;
          end
          if (state[i] == HOLD) count[i*WIDTH +: WIDTH] <= rst_val[i];
        end else if (state[i] == RUN) begin
          if (cur[i] == term[i]) begin
            done[i] <= 1'b1;
            if (ONESHOT) begin
              state[i] <= HOLD;
              busy[i]  <= 1'b0;
            end else begin
              count[i*WIDTH +: WIDTH] <= rst_val[i];
            end
          end else if (dir[i]) begin
            count[i*WIDTH +: WIDTH] <= cur[i] - 1'b1;
          end else begin
            count[i*WIDTH +: WIDTH] <= cur[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_mode_counter.sv
// tb/tb_multi_mode_counter.sv - scoreboard bench for wrapping and one-shot counter instances
// Stimulus drives a reference model that queues expected outputs; a monitor pops and compares.
module tb_multi_mode_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  start, stop, dir, load;
  logic [15:0] load_val;
  logic [7:0]  limit;
  logic [15:0] count_w, count_o;
  logic [1:0]  busy_w, busy_o, done_w, done_o;

  always #5 clk = ~clk;

  multi_mode_counter #(.WIDTH(8), .CHANNELS(2), .ONESHOT(1'b0)) dut_w (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir), .load(load),
    .load_val(load_val), .limit(limit), .count(count_w), .busy(busy_w), .done(done_w)
  );

  multi_mode_counter #(.WIDTH(8), .CHANNELS(2), .ONESHOT(1'b1)) dut_o (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir), .load(load),
    .load_val(load_val), .limit(limit), .count(count_o), .busy(busy_o), .done(done_o)
  );

  typedef struct packed {
    logic [15:0] cw;
    logic [15:0] co;
    logic [1:0]  bw;
    logic [1:0]  bo;
    logic [1:0]  dw;
    logic [1:0]  dov;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  // Reference: inst 0 wraps, inst 1 is one-shot; run/hold flags instead of an FSM encoding.
  int m_val  [2][2];
  bit m_run  [2][2];
  bit m_hold [2][2];
  bit m_done [2][2];

  task automatic model_step();
    exp_t x;
    for (int inst = 0; inst < 2; inst++) begin
      for (int ch = 0; ch < 2; ch++) begin
        int lim, term, rs;
        lim  = int'(limit);
        term = dir[ch] ? 0 : lim;
        rs   = dir[ch] ? lim : 0;
        m_done[inst][ch] = 1'b0;
        if (!reset) begin
          m_val[inst][ch]  = 0;
          m_run[inst][ch]  = 1'b0;
          m_hold[inst][ch] = 1'b0;
        end else if (load[ch]) begin
          m_val[inst][ch] = int'(load_val[ch*8 +: 8]);
        end else if (stop[ch]) begin
          m_run[inst][ch] = 1'b0;
        end else if (start[ch]) begin
          if (!m_run[inst][ch]) begin
            if (m_hold[inst][ch]) m_val[inst][ch] = rs;
            m_hold[inst][ch] = 1'b0;
            m_run[inst][ch]  = 1'b1;
          end
        end else if (m_run[inst][ch]) begin
          if (m_val[inst][ch] == term) begin
            m_done[inst][ch] = 1'b1;
            if (inst == 1) begin
              m_run[inst][ch]  = 1'b0;
              m_hold[inst][ch] = 1'b1;
            end else begin
              m_val[inst][ch] = rs;
            end
          end else begin
            m_val[inst][ch] = dir[ch] ? (m_val[inst][ch] + 255) % 256
                                      : (m_val[inst][ch] + 1) % 256;
          end
        end
      end
    end
    for (int ch = 0; ch < 2; ch++) begin
      x.cw[ch*8 +: 8] = 8'(m_val[0][ch]);
      x.co[ch*8 +: 8] = 8'(m_val[1][ch]);
      x.bw[ch]  = m_run[0][ch];
      x.bo[ch]  = m_run[1][ch];
      x.dw[ch]  = m_done[0][ch];
      x.dov[ch] = m_done[1][ch];
    end
    q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      cyc++;
      e = q.pop_front();
      chk("count_wrap",    count_w,        e.cw);
      chk("count_oneshot", count_o,        e.co);
      chk("busy_wrap",     {14'd0, busy_w}, {14'd0, e.bw});
      chk("busy_oneshot",  {14'd0, busy_o}, {14'd0, e.bo});
      chk("done_wrap",     {14'd0, done_w}, {14'd0, e.dw});
      chk("done_oneshot",  {14'd0, done_o}, {14'd0, e.dov});
    end
  end

  task automatic step();
    model_step();
    @(negedge clk);
    start = '0;
    stop  = '0;
    load  = '0;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    reset = 1'b0; start = '0; stop = '0; dir = '0; load = '0;
    load_val = '0; limit = '0;
    @(negedge clk);
    cycles(2);
    reset = 1'b1;
    cycles(1);

    limit = 8'd3;
    start = 2'b01; cycles(9);
    stop = 2'b01; cycles(2);

    dir = 2'b10; load = 2'b10; load_val = 16'h0500; cycles(1);
    start = 2'b10; cycles(9);
    start = 2'b10; cycles(3);
    load = 2'b10; stop = 2'b10; load_val = 16'h2A00; cycles(3);
    stop = 2'b10; cycles(1);

    limit = 8'd0; dir = 2'b00; start = 2'b01; cycles(4);
    stop = 2'b01; cycles(1);

    limit = 8'd4; load = 2'b01; load_val = 16'h00FE; cycles(1);
    start = 2'b01; cycles(10);

    load = 2'b01; load_val = 16'h0007; cycles(1);
    reset = 1'b0; start = 2'b11; load = 2'b01; cycles(1);
    reset = 1'b1; cycles(3);

    limit = 8'd2; dir = 2'b10; load = 2'b10; load_val = 16'h0200; cycles(1);
    start = 2'b11; cycles(4);
    stop = 2'b01; cycles(4);
    stop = 2'b10; cycles(1);

    for (int k = 0; k < 600; k++) begin
      reset    = ($urandom_range(0, 99) != 0);
      start    = 2'($urandom_range(0, 7) == 0) | (2'($urandom_range(0, 7) == 0) << 1);
      stop     = 2'($urandom_range(0, 15) == 0) | (2'($urandom_range(0, 15) == 0) << 1);
      load     = 2'($urandom_range(0, 15) == 0) | (2'($urandom_range(0, 15) == 0) << 1);
      load_val = 16'($urandom);
      if ($urandom_range(0, 19) == 0) dir = 2'($urandom);
      if ($urandom_range(0, 29) == 0)
        limit = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      cycles(1);
    end
    reset = 1'b1;

    @(posedge clk);
    #2;
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
